// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols, their {C1,C0} codes, aligner states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tmds_pkg;

    // The four 10-bit TMDS control-period symbols
    localparam logic [9:0] TMDS_CTRL_TOK_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_TOK_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_TOK_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_TOK_11 = 10'h2AB;

    // {C1,C0} carried by each control symbol
    localparam logic [1:0] TMDS_CTRL_CODE_00 = 2'b00;
    localparam logic [1:0] TMDS_CTRL_CODE_01 = 2'b01;
    localparam logic [1:0] TMDS_CTRL_CODE_10 = 2'b10;
    localparam logic [1:0] TMDS_CTRL_CODE_11 = 2'b11;

    // Word-aligner lock states
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } aligner_state_e;

endpackage

// File: rtl/tmds_ctrl_detect.sv
// Classifies a 10-bit TMDS symbol as a control token and extracts {C1,C0}.
// Latency: purely combinational.
// Backpressure: none; evaluates every symbol presented.
module tmds_ctrl_detect
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl
);

    // Exact-match decode; anything else is a data/guard symbol
    always_comb begin
        is_ctrl = 1'b0;
        ctrl    = 2'b00;
        case (sym)
            TMDS_CTRL_TOK_00: begin is_ctrl = 1'b1; ctrl = TMDS_CTRL_CODE_00; end
            TMDS_CTRL_TOK_01: begin is_ctrl = 1'b1; ctrl = TMDS_CTRL_CODE_01; end
            TMDS_CTRL_TOK_10: begin is_ctrl = 1'b1; ctrl = TMDS_CTRL_CODE_10; end
            TMDS_CTRL_TOK_11: begin is_ctrl = 1'b1; ctrl = TMDS_CTRL_CODE_11; end
            default:          begin is_ctrl = 1'b0; ctrl = 2'b00; end
        endcase
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// Finds the 10-bit symbol boundary in a deserialized TMDS stream by hunting for runs of control tokens.
// Latency: 1 cycle from the raw word that completes a symbol to word_out.
// Backpressure: none; one word accepted and one produced every clk_pixel cycle.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOSS_TIMEOUT  = 8192
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] raw_in,
    input  logic       force_resync,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       ctrl_valid,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int RUN_W = $clog2(LOCK_COUNT) + 1;
    localparam int WIN_W = $clog2(SEARCH_WINDOW) + 1;
    localparam int GAP_W = $clog2(LOSS_TIMEOUT) + 1;

    // Terminal values: the count held in the register when the current word decides the outcome
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOSS_TIMEOUT - 1);

    aligner_state_e   state_q, state_d;
    logic [3:0]       offset_q, offset_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic [9:0]       raw_prev_q;
    logic [9:0]       word_out_q;
    logic             ctrl_valid_q;
    logic [1:0]       ctrl_q;

    logic [19:0]      window;
    logic [9:0]       aligned;
    logic             aligned_is_ctrl;
    logic [1:0]       aligned_ctrl;

    // Bit offsets cycle 0..9; a symbol boundary can sit at any of the ten bit positions
    function automatic logic [3:0] next_offset(input logic [3:0] cur);
        return (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
    endfunction

    // Two consecutive raw words always contain one whole symbol at the current offset
    assign window  = {raw_in, raw_prev_q};
    assign aligned = window[offset_q +: 10];

    tmds_ctrl_detect u_ctrl_detect (
        .sym     (aligned),
        .is_ctrl (aligned_is_ctrl),
        .ctrl    (aligned_ctrl)
    );

    // Lock FSM next state: force_resync beats lock/timeout, lock beats window expiry
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        run_cnt_d = run_cnt_q;
        win_cnt_d = win_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (force_resync) begin
            state_d   = SEARCH;
            offset_d  = next_offset(offset_q);
            run_cnt_d = '0;
            win_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    gap_cnt_d = '0;
                    if (aligned_is_ctrl && (run_cnt_q == RUN_LAST)) begin
                        state_d   = LOCKED;
                        run_cnt_d = '0;
                        win_cnt_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        offset_d  = next_offset(offset_q);
                        run_cnt_d = '0;
                        win_cnt_d = '0;
                    end else begin
                        if (aligned_is_ctrl) begin
                            run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
                        end else begin
                            run_cnt_d = '0;
                        end
                        win_cnt_d = (win_cnt_q == '1) ? win_cnt_q : win_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    run_cnt_d = '0;
                    win_cnt_d = '0;
                    if (aligned_is_ctrl) begin
                        gap_cnt_d = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d   = SEARCH;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Lock FSM state, bit offset and counters
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q   <= SEARCH;
            offset_q  <= 4'd0;
            run_cnt_q <= '0;
            win_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            run_cnt_q <= run_cnt_d;
            win_cnt_q <= win_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Raw-word history and registered aligned output, updated in both states
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            raw_prev_q   <= 10'd0;
            word_out_q   <= 10'd0;
            ctrl_valid_q <= 1'b0;
            ctrl_q       <= 2'b00;
        end else begin
            raw_prev_q   <= raw_in;
            word_out_q   <= aligned;
            ctrl_valid_q <= aligned_is_ctrl;
            ctrl_q       <= aligned_ctrl;
        end
    end

    // state_q updates on the same edge as word_out_q, so lock status lines up with its word
    assign word_out   = word_out_q;
    assign ctrl_valid = ctrl_valid_q;
    assign ctrl       = ctrl_q;
    assign locked     = (state_q == LOCKED);
    assign word_valid = (state_q == LOCKED);
    assign offset     = offset_q;

endmodule
